// File: rtl/note_sequencer.sv
// Melody sequencer: CPU-filled FIFO of {duration, note} words played back-to-back
// onto the beep mode register, with a fixed silent gap and a done pulse on drain.
module note_sequencer #(
  parameter int DEPTH       = 16,
  parameter int TICK_CYCLES = 625000,
  parameter int GAP_TICKS   = 1
) (
  input  logic        clk_62p5mhz,
  input  logic        reset,
  input  logic        wr_en,
  input  logic [15:0] wr_data,
  input  logic        clear,
  output logic [7:0]  mode,
  output logic [31:0] status,
  output logic        done_irq
);

  localparam int             AW         = $clog2(DEPTH);
  localparam int             PW         = $clog2(TICK_CYCLES);
  localparam logic [PW-1:0]  PRESC_LAST = PW'(TICK_CYCLES - 1);
  localparam logic [7:0]     GAP_INIT   = 8'(GAP_TICKS);
  localparam bit             NO_GAP     = (GAP_TICKS == 0);

  typedef enum logic [1:0] {IDLE, LOAD, PLAY, GAP} state_e;

  logic [15:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [8:0]    count_q, count_d;
  logic          overflow_q;

  state_e        state_q;
  logic [7:0]    note_q, dur_q, dur_cnt_q, mode_q;
  logic [PW-1:0] presc_q;
  logic          done_q;

  logic        empty, full, push, pop;
  logic        tick_wrap, last_tick, note_end;
  logic [15:0] head;

  assign empty     = (count_q == 9'd0);
  assign full      = (count_q == 9'(DEPTH));
  assign push      = wr_en && !full && !clear;
  assign head      = mem_q[rd_ptr_q];
  assign tick_wrap = (presc_q == PRESC_LAST);
  assign last_tick = tick_wrap && (dur_cnt_q == 8'd1);
  // The end of a note (or of its gap) is the only other point that pulls the next word.
  assign note_end  = (state_q == PLAY && last_tick && NO_GAP) || (state_q == GAP && last_tick);
  assign pop       = !clear && !empty &&
                     ((state_q == IDLE) || (state_q == LOAD && dur_q == 8'd0) || note_end);

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 9'd1;
      2'b01:   count_d = count_q - 9'd1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: storage is deliberately left out of reset; only the pointers and count define validity.
  always_ff @(posedge clk_62p5mhz) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

  always_ff @(posedge clk_62p5mhz) begin
    if (reset || clear) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
      if (wr_en && full) overflow_q <= 1'b1;
    end
  end

  always_ff @(posedge clk_62p5mhz) begin
    if (reset) begin
      state_q   <= IDLE;
      mode_q    <= 8'd0;
      done_q    <= 1'b0;
      presc_q   <= '0;
      dur_cnt_q <= 8'd0;
      note_q    <= 8'd0;
      dur_q     <= 8'd0;
    end else if (clear) begin
      state_q <= IDLE;
      mode_q  <= 8'd0;
      done_q  <= 1'b0;
      presc_q <= '0;
    end else begin
      done_q <= 1'b0;
      if (pop) begin
        note_q <= head[7:0];
        dur_q  <= head[15:8];
      end
      case (state_q)
        IDLE: begin
          mode_q <= 8'd0;
          if (pop) state_q <= LOAD;
        end
        LOAD: begin
          if (dur_q == 8'd0) begin
            state_q <= pop ? LOAD : IDLE;
          end else begin
            mode_q    <= note_q;
            dur_cnt_q <= dur_q;
            presc_q   <= '0;
            state_q   <= PLAY;
          end
        end
        PLAY, GAP: begin
          presc_q <= tick_wrap ? '0 : presc_q + 1'b1;
          if (tick_wrap) dur_cnt_q <= dur_cnt_q - 8'd1;
          if (last_tick) begin
            mode_q <= 8'd0;
            if (state_q == PLAY && !NO_GAP) begin
              state_q   <= GAP;
              dur_cnt_q <= GAP_INIT;
            end else if (pop) begin
              state_q <= LOAD;
            end else begin
              state_q <= IDLE;
              done_q  <= 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mode     = mode_q;
  assign done_irq = done_q;
  assign status   = {20'b0, overflow_q, (state_q != IDLE), full, empty, count_q[7:0]};

endmodule

// File: tb/tb_note_sequencer.sv
// Directed bench for note_sequencer with TICK_CYCLES=4, GAP_TICKS=1, DEPTH=4;
// expected traces are hand-derived cycle positions relative to the push edge.
module tb_note_sequencer;

  logic        clk = 1'b0;
  logic        reset, wr_en, clear;
  logic [15:0] wr_data;
  logic [7:0]  mode;
  logic [31:0] status;
  logic        done_irq;

  int vectors = 0;
  int errors  = 0;

  logic [15:0] t2_words [3];
  logic [7:0]  exp_mode;

  note_sequencer #(.DEPTH(4), .TICK_CYCLES(4), .GAP_TICKS(1)) dut (
    .clk_62p5mhz (clk),
    .reset       (reset),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .clear       (clear),
    .mode        (mode),
    .status      (status),
    .done_irq    (done_irq)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; wr_en = 1'b0; clear = 1'b0; wr_data = '0;
    t2_words[0] = 16'h0101; t2_words[1] = 16'h0105; t2_words[2] = 16'h010A;
    repeat (3) step();
    check("rst_mode", {24'd0, mode}, 32'd0);
    check("rst_status", status, 32'h0000_0100);
    check("rst_done", {31'd0, done_irq}, 32'd0);
    reset = 1'b0;
    step();

    // Single note: mode=3 after edges 2..9, gap to edge 14, done pulse there.
    for (int k = 0; k <= 16; k++) begin
      wr_en = (k == 0); wr_data = 16'h0203;
      step();
      if (k >= 1) begin
        check("t1_mode", {24'd0, mode}, (k >= 2 && k <= 9) ? 32'd3 : 32'd0);
        check("t1_done", {31'd0, done_irq}, 32'(k == 14));
        check("t1_busy", {31'd0, status[10]}, 32'(k < 14));
      end
    end

    // Three queued notes with 5-cycle silences and a single done pulse.
    for (int k = 0; k <= 32; k++) begin
      wr_en = (k < 3);
      wr_data = (k < 3) ? t2_words[k] : 16'h0000;
      step();
      if (k >= 1) begin
        if (k >= 2 && k <= 5)        exp_mode = 8'd1;
        else if (k >= 11 && k <= 14) exp_mode = 8'd5;
        else if (k >= 20 && k <= 23) exp_mode = 8'd10;
        else                         exp_mode = 8'd0;
        check("t2_mode", {24'd0, mode}, {24'd0, exp_mode});
        check("t2_done", {31'd0, done_irq}, 32'(k == 28));
      end
    end
    check("t2_idle", status, 32'h0000_0100);

    // Overflow while a long note holds the player busy; clear beats a same-cycle push.
    wr_en = 1'b1; wr_data = 16'h0A01; step();
    wr_en = 1'b0; step();
    for (int i = 0; i < 5; i++) begin
      wr_en = 1'b1; wr_data = 16'h0111 + 16'(i);
      step();
      if (i == 0) check("t3_mode", {24'd0, mode}, 32'd1);
      if (i == 3) check("t3_full", status, 32'h0000_0604);
      if (i == 4) check("t3_ovf", status, 32'h0000_0E04);
    end
    clear = 1'b1; wr_data = 16'h0222; step();
    clear = 1'b0; wr_en = 1'b0;
    check("t3_clr_status", status, 32'h0000_0100);
    check("t3_clr_mode", {24'd0, mode}, 32'd0);
    check("t3_clr_done", {31'd0, done_irq}, 32'd0);
    repeat (2) step();
    check("t3_after_clr", status, 32'h0000_0100);

    // Zero-duration entry is skipped: note 7 never shows, note 2 after edges 3..6.
    for (int k = 0; k <= 12; k++) begin
      wr_en = (k < 2);
      wr_data = (k == 0) ? 16'h0007 : 16'h0102;
      step();
      if (k >= 1) begin
        check("t4_mode", {24'd0, mode}, (k >= 3 && k <= 6) ? 32'd2 : 32'd0);
        check("t4_done", {31'd0, done_irq}, 32'(k == 11));
      end
    end

    // Clear in the middle of a note with two entries queued.
    for (int k = 0; k < 4; k++) begin
      wr_en = (k < 3); wr_data = 16'h0301 + 16'(k);
      step();
    end
    check("t5_playing", {24'd0, mode}, 32'd1);
    check("t5_queued", status, 32'h0000_0402);
    clear = 1'b1; step(); clear = 1'b0;
    check("t5_mode", {24'd0, mode}, 32'd0);
    check("t5_status", status, 32'h0000_0100);
    check("t5_done", {31'd0, done_irq}, 32'd0);
    for (int k = 0; k < 20; k++) begin
      step();
      check("t5_quiet_done", {31'd0, done_irq}, 32'd0);
      check("t5_quiet_mode", {24'd0, mode}, 32'd0);
    end

    // Push/pop on the same edge, then push into a full FIFO on a pop edge.
    wr_en = 1'b1; wr_data = 16'h0101; step();
    wr_en = 1'b0; step();
    wr_en = 1'b1; wr_data = 16'h0102; step();
    wr_data = 16'h0103; step();
    wr_en = 1'b0;
    check("t6_cnt2", status, 32'h0000_0402);
    repeat (6) step();
    wr_en = 1'b1; wr_data = 16'h0104; step();
    check("t6_pushpop", status, 32'h0000_0402);
    wr_data = 16'h0105; step();
    check("t6_next_note", {24'd0, mode}, 32'd2);
    check("t6_cnt3", status, 32'h0000_0403);
    wr_data = 16'h0106; step();
    check("t6_full", status, 32'h0000_0604);
    wr_en = 1'b0;
    repeat (6) step();
    check("t6_gap_mode", {24'd0, mode}, 32'd0);
    check("t6_still_full", status, 32'h0000_0604);
    wr_en = 1'b1; wr_data = 16'h0107; step();
    check("t6_drop", status, 32'h0000_0C03);
    wr_en = 1'b0; step();
    check("t6_note3", {24'd0, mode}, 32'd3);
    clear = 1'b1; step(); clear = 1'b0;
    check("t6_clr", status, 32'h0000_0100);

    // Reset mid-note silences mode on the next edge.
    wr_en = 1'b1; wr_data = 16'h0204; step();
    wr_en = 1'b0; repeat (2) step();
    check("t7_playing", {24'd0, mode}, 32'd4);
    reset = 1'b1; clear = 1'b1; step();
    reset = 1'b0; clear = 1'b0;
    check("t7_mode", {24'd0, mode}, 32'd0);
    check("t7_status", status, 32'h0000_0100);
    check("t7_done", {31'd0, done_irq}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
